// File: rtl/mapache64.sv
// Shared mapache64 types and constants used by the controller reader and its CPU decode.
package mapache64;

    localparam int unsigned DATA_W          = 8;
    localparam int unsigned ADDRESS_W       = 16;
    localparam int unsigned CONTROLLER_BITS = 8;

    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [ADDRESS_W-1:0] address_t;

    // CPU-visible addresses decoded into SELECT_controller_1_i / SELECT_controller_2_i
    localparam address_t CONTROLLER_1_ADDRESS = 16'h1800;
    localparam address_t CONTROLLER_2_ADDRESS = 16'h1801;

    // Committed button state of both pads
    typedef struct packed {
        data_t ctrl1;
        data_t ctrl2;
    } controller_pair_t;

    typedef enum logic [2:0] {
        CR_IDLE   = 3'd0,
        CR_LATCH  = 3'd1,
        CR_LOW    = 3'd2,
        CR_HIGH   = 3'd3,
        CR_COMMIT = 3'd4
    } controller_reader_state_t;

endpackage

// File: rtl/controller_reader_if.sv
// Controller pad pins plus the CPU read port of the controller reader.
interface controller_reader_if;
    import mapache64::*;

    logic  latch_o;
    logic  pulse_o;
    logic  serial_1_i;
    logic  serial_2_i;
    logic  SELECT_controller_1_i;
    logic  SELECT_controller_2_i;
    data_t data_o;

    // master: the reader itself; slave: pads and CPU side
    modport master (
        output latch_o,
        output pulse_o,
        output data_o,
        input  serial_1_i,
        input  serial_2_i,
        input  SELECT_controller_1_i,
        input  SELECT_controller_2_i
    );

    modport slave (
        input  latch_o,
        input  pulse_o,
        input  data_o,
        output serial_1_i,
        output serial_2_i,
        output SELECT_controller_1_i,
        output SELECT_controller_2_i
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/controller_reader.sv
// Reads two serial game pads once per frame and holds the last complete button
// state for CPU reads.
module controller_reader
    import mapache64::*;
#(
    parameter int unsigned TICK_DIV = 76
) (
    input  logic gpu_clk,
    input  logic rst,
    input  logic start_fetch_i,
    output logic busy_o,
    output logic fetch_done_o,
    controller_reader_if.master bus
);

    localparam int unsigned PHASE_W = $clog2(2 * TICK_DIV);
    localparam int unsigned BIT_W   = $clog2(CONTROLLER_BITS);

    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * TICK_DIV - 1);
    localparam logic [PHASE_W-1:0] TICK_LAST  = PHASE_W'(TICK_DIV - 1);
    localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(CONTROLLER_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'(CR_IDLE);
    localparam logic [2:0] S_LATCH  = 3'(CR_LATCH);
    localparam logic [2:0] S_LOW    = 3'(CR_LOW);
    localparam logic [2:0] S_HIGH   = 3'(CR_HIGH);
    localparam logic [2:0] S_COMMIT = 3'(CR_COMMIT);

    logic [2:0]         state;
    logic [2:0]         state_next;
    logic [PHASE_W-1:0] phase_cnt;
    logic [BIT_W-1:0]   bit_count;
    logic               start_q;
    logic               fetch_edge_c;
    logic               serial_1_s;
    logic               serial_2_s;
    logic               latch_q;
    logic               pulse_q;
    data_t              shift1;
    data_t              shift2;
    controller_pair_t   ctrl;

    // Pad data lines are asynchronous to gpu_clk
    sync_2ff u_sync_serial_1 (
        .clk (gpu_clk),
        .rst (rst),
        .d   (bus.serial_1_i),
        .q   (serial_1_s)
    );

    sync_2ff u_sync_serial_2 (
        .clk (gpu_clk),
        .rst (rst),
        .d   (bus.serial_2_i),
        .q   (serial_2_s)
    );

    assign fetch_edge_c = start_fetch_i & ~start_q;

    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (fetch_edge_c) state_next = S_LATCH;
            S_LATCH:  if (phase_cnt == LATCH_LAST) state_next = S_LOW;
            S_LOW:    if (phase_cnt == TICK_LAST) state_next = S_HIGH;
            S_HIGH: begin
                if (phase_cnt == TICK_LAST) begin
                    state_next = (bit_count == LAST_BIT) ? S_COMMIT : S_LOW;
                end
            end
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath and pin flops; pin levels follow the state being entered so they
    // line up with the state register and come straight from flops.
    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            start_q      <= 1'b0;
            phase_cnt    <= '0;
            bit_count    <= '0;
            shift1       <= '0;
            shift2       <= '0;
            ctrl         <= '0;
            latch_q      <= 1'b0;
            pulse_q      <= 1'b0;
            busy_o       <= 1'b0;
            fetch_done_o <= 1'b0;
        end else begin
            start_q <= start_fetch_i;

            if (state_next != state || state == S_IDLE) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + PHASE_W'(1);
            end

            if (state == S_IDLE && state_next == S_LATCH) begin
                bit_count <= '0;
            end else if (state == S_HIGH && state_next == S_LOW) begin
                bit_count <= bit_count + BIT_W'(1);
            end

            // Sample just before the shift clock rises; pins are active low
            if (state == S_LOW && phase_cnt == TICK_LAST) begin
                shift1[bit_count] <= ~serial_1_s;
                shift2[bit_count] <= ~serial_2_s;
            end

            if (state == S_COMMIT) begin
                ctrl.ctrl1 <= shift1;
                ctrl.ctrl2 <= shift2;
            end

            latch_q      <= (state_next == S_LATCH);
            pulse_q      <= (state_next == S_HIGH);
            busy_o       <= (state_next != S_IDLE);
            fetch_done_o <= (state_next == S_COMMIT);
        end
    end

    assign bus.latch_o = latch_q;
    assign bus.pulse_o = pulse_q;

    // Controller 1 has priority when both selects are asserted
    assign bus.data_o = bus.SELECT_controller_1_i ? ctrl.ctrl1 :
                        bus.SELECT_controller_2_i ? ctrl.ctrl2 : '0;

endmodule

// File: doc/controller_reader.md
CONTROLLER_READER -- requirements
Module: controller_reader

Interface
REQ-001 SHALL expose parameter TICK_DIV, default 76, gpu_clk cycles per controller bit phase (about 6 us at 12.5875 MHz); legal range 4..1023.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: gpu_clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start_fetch_i  input  1  fetch request level from the GPU, high for the first 32 hcounter cycles of frame line 0.
REQ-005 serial_1_i, serial_2_i  input  1 each  active-low controller data pins, asynchronous.
REQ-006 latch_o  output  1  shared controller latch strobe.
REQ-007 pulse_o  output  1  shared controller shift clock.
REQ-008 SELECT_controller_1_i, SELECT_controller_2_i  input  1 each  CPU read selects.
REQ-009 data_o  output  mapache64::data_t  CPU read data.
REQ-010 busy_o  output  1  fetch in progress.
REQ-011 fetch_done_o  output  1  one-cycle pulse on commit.

Function
REQ-012 SHALL pass serial_1_i and serial_2_i through 2-flop synchronizers before any use.
REQ-013 SHALL register start_fetch_i and accept a fetch only on its rising edge while in IDLE; edges in any other state are ignored.
REQ-014 SHALL have the states IDLE, LATCH, LOW, HIGH and COMMIT.
REQ-015 SHALL have a phase counter that clears on every state entry.
REQ-016 IDLE -> LATCH SHALL occur on the cycle after the edge is detected; bit_count SHALL clear to 0 on this transition.
REQ-017 LATCH: latch_o=1 for exactly 2*TICK_DIV cycles, then -> LOW.
REQ-018 LOW: pulse_o=0 for TICK_DIV cycles; on the last cycle, sample the inverted synchronized serial_1 into shift1[bit_count] and serial_2 into shift2[bit_count]; then -> HIGH.
REQ-019 HIGH: pulse_o=1 for TICK_DIV cycles; then -> COMMIT if bit_count==7, else increment bit_count and -> LOW.
REQ-020 COMMIT: one cycle; ctrl1<=shift1, ctrl2<=shift2, fetch_done_o=1; then -> IDLE.
REQ-021 Bit 0 SHALL hold the first serial bit (button A), bit 7 the eighth; 1 means pressed.
REQ-022 Total busy time SHALL be 18*TICK_DIV+1 cycles; busy_o=1 in every state except IDLE.
REQ-023 data_o SHALL be combinational: SELECT_controller_1_i ? ctrl1 : SELECT_controller_2_i ? ctrl2 : 0; controller 1 wins if both selects are high.
REQ-024 ctrl1 and ctrl2 SHALL change only in COMMIT, so a CPU read never returns a partial fetch.
REQ-025 latch_o and pulse_o SHALL be driven directly from flops, glitch-free, and both low outside LATCH and HIGH respectively.
REQ-026 A rising edge of start_fetch_i on the same cycle as COMMIT SHALL be ignored.

Reset
REQ-027 On rst, state SHALL go to IDLE immediately.
REQ-028 On rst, latch_o, pulse_o, busy_o, fetch_done_o, ctrl1, ctrl2, the shift registers, the counters, the synchronizers and the registered start_fetch_i SHALL all be 0.
REQ-029 Reset mid-fetch SHALL abort without committing; the next fetch requires a fresh rising edge after rst is released.

Structure
REQ-030 The mapache64 package SHALL hold CONTROLLER_BITS=8 and the state enum controller_reader_state_t.
REQ-031 The mapache64 package SHALL also hold the new address constants for the two select decodes.
REQ-032 SHALL instantiate sub-module sync_2ff, once per serial input.
REQ-033 All other logic SHALL be flat in controller_reader.

Verification (TICK_DIV=4 unless stated)
REQ-034 Fetch with serial_1_i driving A,B,Select,Start,Up,Down,Left,Right = 0,1,1,1,1,1,1,0 -> ctrl1 reads 8'h81; fetch_done_o pulses exactly 73 cycles after the edge-detect cycle; latch_o is high exactly 8 cycles; pulse_o shows exactly 8 high periods.
REQ-035 serial_2_i held low during a fetch -> ctrl2 reads 8'hFF; with both selects high, data_o shows ctrl1.
REQ-036 start_fetch_i rising again at cycle 20 of a fetch -> ignored; exactly one fetch_done_o; busy_o stays high through the whole fetch.
REQ-037 Previous ctrl1=8'h81 with new data 8'h3C -> CPU reads during the fetch return 8'h81 until the COMMIT cycle, and 8'h3C from the next cycle.
REQ-038 rst asserted at cycle 40 of a fetch -> all outputs 0 asynchronously; ctrl1 stays 0 after release; the next edge completes a normal fetch.
REQ-039 TICK_DIV=76 -> busy_o high for exactly 1369 cycles.
